// File: rtl/csr_access_unit.sv
// csr_access_unit
//    Responder side of the CSR port. It executes Zicsr requests (CSRRW/S/C
//    and the immediate forms) against the machine-mode CSRs as a
//    read-modify-write. It also sequences external-interrupt trap entry and
//    mret. resp_rdata feeds the rd writeback mux.
//
// Ports
//    clk, rst          clock, asynchronous active-high reset
//    req_valid/ready   request handshake (ready only while idle and not
//                      busy with mret or trap entry)
//    req_op            funct3 (001 RW, 010 RS, 011 RC, 101/110/111 imm forms)
//    req_addr          12-bit CSR address
//    req_wdata         rs1 value or zero-extended uimm
//    req_src_zero      rs1==x0 / uimm==0, suppresses RS/RC style writes
//    resp_valid        one-cycle pulse carrying resp_rdata / resp_illegal
//    irq, cur_pc       level interrupt request and the PC saved on entry
//    trap_take/trap_pc one-cycle trap-entry pulse and the mtvec target
//    mret, mret_pc     mret strobe and the current mepc
//
// Configuration
//    CSR_CYCLE_COUNTER_EN  adds the 64-bit mcycle/mcycleh counter at
//                          0xB00/0xB80; without it those addresses are
//                          unmapped.

module csr_access_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] MCAUSE_EI = 32'h8000000B
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [11:0]     req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic            req_src_zero,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_illegal,
   input  logic            irq,
   input  logic [XLEN-1:0] cur_pc,
   output logic            trap_take,
   output logic [XLEN-1:0] trap_pc,
   input  logic            mret,
   output logic [XLEN-1:0] mret_pc
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MIE      = 12'h304;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef CSR_CYCLE_COUNTER_EN
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
`endif

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MEIE_BIT = 11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [11:0]       addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              src_zero_q, src_zero_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              illegal_q, illegal_d;
   logic              mstatus_mie_q, mstatus_mie_d;
   logic              mstatus_mpie_q, mstatus_mpie_d;
   logic              mie_meie_q, mie_meie_d;
   logic [XLEN-1:0]   mtvec_q, mtvec_d;
   logic [XLEN-1:0]   mscratch_q, mscratch_d;
   logic [XLEN-1:0]   mepc_q, mepc_d;
   logic [XLEN-1:0]   mcause_q, mcause_d;
`ifdef CSR_CYCLE_COUNTER_EN
   logic [63:0]       mcycle_q, mcycle_d;
`endif

   logic [XLEN-1:0]   old_val;
   logic [XLEN-1:0]   new_val;
   logic              mapped;
   logic              read_only;
   logic              op_legal;
   logic              op_is_rw;
   logic              write_req;
   logic              illegal;
   logic              do_write;
   logic              irq_pending;

   // Read view of the latched address. Unstored bits read as zero, and mip
   // reflects the live irq level rather than any stored state.
   always_comb begin
      old_val   = '0;
      mapped    = 1'b1;
      read_only = 1'b0;
      case (addr_q)
         ADDR_MSTATUS: begin
            old_val[MIE_BIT]  = mstatus_mie_q;
            old_val[MPIE_BIT] = mstatus_mpie_q;
         end
         ADDR_MIE:      old_val[MEIE_BIT] = mie_meie_q;
         ADDR_MTVEC:    old_val = mtvec_q;
         ADDR_MSCRATCH: old_val = mscratch_q;
         ADDR_MEPC:     old_val = mepc_q;
         ADDR_MCAUSE:   old_val = mcause_q;
         ADDR_MIP: begin
            old_val[MEIE_BIT] = irq;
            read_only         = 1'b1;
         end
`ifdef CSR_CYCLE_COUNTER_EN
         ADDR_MCYCLE:   old_val = mcycle_q[31:0];
         ADDR_MCYCLEH:  old_val = mcycle_q[63:32];
`endif
         default:       mapped = 1'b0;
      endcase
   end

   // Operation decode and write qualification. RW forms always write; the
   // set/clear forms skip the write when the source is x0 or uimm 0, which
   // also lets them read mip without being flagged illegal.
   always_comb begin
      op_legal = 1'b1;
      op_is_rw = 1'b0;
      new_val  = old_val;
      case (op_q)
         3'b001, 3'b101: begin
            op_is_rw = 1'b1;
            new_val  = wdata_q;
         end
         3'b010, 3'b110: new_val = old_val | wdata_q;
         3'b011, 3'b111: new_val = old_val & ~wdata_q;
         default:        op_legal = 1'b0;
      endcase
      write_req = op_is_rw || !src_zero_q;
      illegal   = !mapped || !op_legal || (write_req && read_only);
      do_write  = write_req && !illegal;
   end

   assign irq_pending = irq && mstatus_mie_q && mie_meie_q;

   // Sequencer. In idle, mret wins over trap entry, which wins over a new
   // request; both mret and trap entry hold off req_ready for that cycle so
   // a waiting request is accepted afterwards.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      src_zero_d     = src_zero_q;
      rdata_d        = rdata_q;
      illegal_d      = illegal_q;
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_meie_d     = mie_meie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      req_ready      = 1'b0;
      trap_take      = 1'b0;
`ifdef CSR_CYCLE_COUNTER_EN
      mcycle_d       = mcycle_q + 64'd1;
`endif
      case (state_q)
         ST_IDLE: begin
            if (mret) begin
               mstatus_mie_d  = mstatus_mpie_q;
               mstatus_mpie_d = 1'b1;
            end else if (irq_pending) begin
               trap_take      = 1'b1;
               mepc_d         = cur_pc & ~XLEN'(3);
               mcause_d       = MCAUSE_EI;
               mstatus_mpie_d = mstatus_mie_q;
               mstatus_mie_d  = 1'b0;
            end else begin
               req_ready = 1'b1;
               if (req_valid) begin
                  op_d       = req_op;
                  addr_d     = req_addr;
                  wdata_d    = req_wdata;
                  src_zero_d = req_src_zero;
                  state_d    = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            rdata_d   = illegal ? '0 : old_val;
            illegal_d = illegal;
            if (do_write) begin
               case (addr_q)
                  ADDR_MSTATUS: begin
                     mstatus_mie_d  = new_val[MIE_BIT];
                     mstatus_mpie_d = new_val[MPIE_BIT];
                  end
                  ADDR_MIE:      mie_meie_d = new_val[MEIE_BIT];
                  ADDR_MTVEC:    mtvec_d    = new_val & ~XLEN'(3);
                  ADDR_MSCRATCH: mscratch_d = new_val;
                  ADDR_MEPC:     mepc_d     = new_val & ~XLEN'(3);
                  ADDR_MCAUSE:   mcause_d   = new_val;
`ifdef CSR_CYCLE_COUNTER_EN
                  ADDR_MCYCLE:   mcycle_d   = {mcycle_q[63:32], new_val};
                  ADDR_MCYCLEH:  mcycle_d   = {new_val, mcycle_q[31:0]};
`endif
                  default: ;
               endcase
            end
            state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and CSR registers. Reset drops any in-flight request, so a write
   // that has not reached the end of its execute cycle never lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         op_q           <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         src_zero_q     <= 1'b0;
         rdata_q        <= '0;
         illegal_q      <= 1'b0;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_meie_q     <= 1'b0;
         mtvec_q        <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
`ifdef CSR_CYCLE_COUNTER_EN
         mcycle_q       <= '0;
`endif
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         src_zero_q     <= src_zero_d;
         rdata_q        <= rdata_d;
         illegal_q      <= illegal_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_meie_q     <= mie_meie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
`ifdef CSR_CYCLE_COUNTER_EN
         mcycle_q       <= mcycle_d;
`endif
      end
   end

   assign resp_valid   = (state_q == ST_RESP);
   assign resp_rdata   = rdata_q;
   assign resp_illegal = resp_valid && illegal_q;
   assign trap_pc      = mtvec_q;
   assign mret_pc      = mepc_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit
//    Self-checking bench for csr_access_unit. Requests push their expected
//    response into a queue; a monitor pops and compares whenever resp_valid
//    is seen. Expected values come from a register-level model of the CSR
//    file kept here (masks per CSR, plain read-modify-write arithmetic).
//    Directed sequences cover reset, trap entry, mret, priority and reset
//    in the middle of a request; a randomized loop covers the rest.

`timescale 1ns/1ps

module tb_csr_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_src_zero;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_illegal;
   logic        irq;
   logic [31:0] cur_pc;
   logic        trap_take;
   logic [31:0] trap_pc;
   logic        mret;
   logic [31:0] mret_pc;

   csr_access_unit dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_src_zero (req_src_zero),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_illegal (resp_illegal),
      .irq          (irq),
      .cur_pc       (cur_pc),
      .trap_take    (trap_take),
      .trap_pc      (trap_pc),
      .mret         (mret),
      .mret_pc      (mret_pc)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        illegal;
      int          accept_cycle;
      bit          check_data;
      int          tag;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] cap_val [8];
   int          cap_cycle [8];
   int          checks;
   int          errors;
   int          cycle_num;

   logic [31:0] m_mstatus;
   logic [31:0] m_mie;
   logic [31:0] m_mtvec;
   logic [31:0] m_mepc;
   logic [31:0] m_mscratch;
   logic [31:0] m_mcause;

   logic [11:0] addr_tbl [10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_num <= cycle_num + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not reach its end");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference model: each CSR is a word with its writable mask applied.
   function automatic void model_reset();
      m_mstatus  = '0;
      m_mie      = '0;
      m_mtvec    = '0;
      m_mepc     = '0;
      m_mscratch = '0;
      m_mcause   = '0;
   endfunction

   function automatic void model_access(input logic [2:0] op, input logic [11:0] addr,
                                        input logic [31:0] wdata, input logic src_zero,
                                        input logic irq_lvl,
                                        output logic [31:0] rdata, output logic illegal);
      logic [31:0] old_v;
      logic [31:0] new_v;
      logic        mapped;
      logic        ro;
      logic        is_rw;
      logic        writes;
      mapped = 1'b1;
      ro     = 1'b0;
      old_v  = '0;
      case (addr)
         12'h300: old_v = m_mstatus;
         12'h304: old_v = m_mie;
         12'h305: old_v = m_mtvec;
         12'h340: old_v = m_mscratch;
         12'h341: old_v = m_mepc;
         12'h342: old_v = m_mcause;
         12'h344: begin
            old_v = irq_lvl ? 32'h0000_0800 : 32'h0;
            ro    = 1'b1;
         end
         default: mapped = 1'b0;
      endcase
      is_rw = (op == 3'd1) || (op == 3'd5);
      if (is_rw) new_v = wdata;
      else if (op == 3'd2 || op == 3'd6) new_v = old_v | wdata;
      else new_v = old_v & ~wdata;
      writes  = is_rw || !src_zero;
      illegal = !mapped || (op == 3'd0) || (op == 3'd4) || (writes && ro);
      rdata   = illegal ? 32'h0 : old_v;
      if (writes && !illegal) begin
         case (addr)
            12'h300: m_mstatus  = new_v & 32'h0000_0088;
            12'h304: m_mie      = new_v & 32'h0000_0800;
            12'h305: m_mtvec    = new_v & 32'hFFFF_FFFC;
            12'h340: m_mscratch = new_v;
            12'h341: m_mepc     = new_v & 32'hFFFF_FFFC;
            12'h342: m_mcause   = new_v;
            default: ;
         endcase
      end
   endfunction

   function automatic void model_trap(input logic [31:0] pc);
      m_mepc    = pc & 32'hFFFF_FFFC;
      m_mcause  = 32'h8000_000B;
      m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
   endfunction

   function automatic void model_mret();
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h08 : 32'h0);
   endfunction

   // Waits (bounded) for a negedge at which the unit is idle and ready.
   task automatic wait_ready(input string who);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) checkOutput({who, "_ready_timeout"}, 32'(req_ready), 32'd1);
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic src_zero,
                                input bit capture, input int tag);
      exp_t        e;
      logic [31:0] r;
      logic        ill;
      wait_ready("req");
      req_valid    = 1'b1;
      req_op       = op;
      req_addr     = addr;
      req_wdata    = wdata;
      req_src_zero = src_zero;
      e.accept_cycle = cycle_num;
      e.check_data   = !capture;
      e.tag          = tag;
      if (capture) begin
         e.rdata   = '0;
         e.illegal = 1'b0;
      end else begin
         model_access(op, addr, wdata, src_zero, irq, r, ill);
         e.rdata   = r;
         e.illegal = ill;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Read with a literal expectation (RS with x0, no write).
   task automatic expectRead(input logic [11:0] addr, input logic [31:0] value);
      exp_t e;
      wait_ready("read");
      req_valid    = 1'b1;
      req_op       = 3'b010;
      req_addr     = addr;
      req_wdata    = '0;
      req_src_zero = 1'b1;
      e.accept_cycle = cycle_num;
      e.check_data   = 1'b1;
      e.tag          = 0;
      e.rdata        = value;
      e.illegal      = 1'b0;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic doTrap(input logic [31:0] pc);
      wait_ready("trap");
      irq    = 1'b1;
      cur_pc = pc;
      #1;
      checkOutput("trap_take", 32'(trap_take), 32'd1);
      checkOutput("trap_pc", trap_pc, m_mtvec);
      checkOutput("req_ready_in_trap", 32'(req_ready), 32'd0);
      model_trap(pc);
      @(posedge clk);
      #1;
      irq = 1'b0;
      checkOutput("mepc_after_trap", mret_pc, m_mepc);
   endtask

   task automatic doMret();
      wait_ready("mret");
      checkOutput("mret_pc", mret_pc, m_mepc);
      mret = 1'b1;
      #1;
      checkOutput("req_ready_in_mret", 32'(req_ready), 32'd0);
      model_mret();
      @(posedge clk);
      #1;
      mret = 1'b0;
   endtask

   // Monitor: every response must match the oldest outstanding expectation
   // and arrive two cycles after its accept cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            checkOutput("spurious_resp", 32'(resp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("resp_latency", 32'(cycle_num - e.accept_cycle), 32'd2);
            checkOutput("resp_illegal", 32'(resp_illegal), 32'(e.illegal));
            if (e.check_data) begin
               checkOutput("resp_rdata", resp_rdata, e.rdata);
            end else begin
               cap_val[e.tag]   = resp_rdata;
               cap_cycle[e.tag] = e.accept_cycle;
            end
         end
      end
   end

   initial begin : stimulus
      bit seen_resp;
      addr_tbl = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                   12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0};
      checks       = 0;
      errors       = 0;
      cycle_num    = 0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_op       = '0;
      req_addr     = '0;
      req_wdata    = '0;
      req_src_zero = 1'b0;
      irq          = 1'b0;
      cur_pc       = '0;
      mret         = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset_resp_illegal", 32'(resp_illegal), 32'd0);
      checkOutput("reset_trap_take", 32'(trap_take), 32'd0);
      checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
      checkOutput("reset_trap_pc", trap_pc, 32'h0);
      checkOutput("reset_mret_pc", mret_pc, 32'h0);
      rst = 1'b0;

      $display("[TB] mscratch swap");
      applyStimulus(3'b001, 12'h340, 32'hDEADBEEF, 1'b0, 1'b0, 0);
      applyStimulus(3'b001, 12'h340, 32'h0, 1'b0, 1'b0, 0);

      $display("[TB] trap entry and mret");
      applyStimulus(3'b001, 12'h300, 32'h8, 1'b0, 1'b0, 0);
      applyStimulus(3'b001, 12'h304, 32'h800, 1'b0, 1'b0, 0);
      applyStimulus(3'b001, 12'h305, 32'h100, 1'b0, 1'b0, 0);
      drain();
      doTrap(32'h1236);
      expectRead(12'h341, 32'h1234);
      expectRead(12'h342, 32'h8000000B);
      expectRead(12'h300, 32'h80);
      drain();
      checkOutput("mret_pc_literal", mret_pc, 32'h1234);
      doMret();
      expectRead(12'h300, 32'h88);
      drain();

      $display("[TB] mret and irq together");
      wait_ready("mret_irq");
      mret   = 1'b1;
      irq    = 1'b1;
      cur_pc = 32'h2002;
      #1;
      checkOutput("trap_blocked_by_mret", 32'(trap_take), 32'd0);
      model_mret();
      @(posedge clk);
      #1;
      mret = 1'b0;
      @(negedge clk);
      checkOutput("trap_after_mret", 32'(trap_take), 32'd1);
      checkOutput("trap_pc_after_mret", trap_pc, m_mtvec);
      model_trap(cur_pc);
      @(posedge clk);
      #1;
      irq = 1'b0;
      checkOutput("mepc_second_trap", mret_pc, 32'h2000);

      $display("[TB] suppressed writes, read-only, clear and immediates");
      applyStimulus(3'b010, 12'h304, 32'h0, 1'b1, 1'b0, 0);
      expectRead(12'h304, 32'h800);
      applyStimulus(3'b001, 12'h344, 32'h1, 1'b0, 1'b0, 0);
      applyStimulus(3'b001, 12'h300, 32'h8, 1'b0, 1'b0, 0);
      applyStimulus(3'b011, 12'h300, 32'h8, 1'b0, 1'b0, 0);
      expectRead(12'h300, 32'h0);
      applyStimulus(3'b101, 12'h305, 32'h103, 1'b0, 1'b0, 0);
      expectRead(12'h305, 32'h100);
      drain();

      $display("[TB] randomized requests");
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op;
         logic [11:0] addr;
         logic [31:0] wdata;
         logic        sz;
         if ($urandom_range(0, 9) == 0) begin
            doMret();
         end else begin
            op    = 3'($urandom_range(0, 7));
            addr  = addr_tbl[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) addr = 12'($urandom);
`ifdef CSR_CYCLE_COUNTER_EN
            if (addr == 12'hB00 || addr == 12'hB80) addr = 12'h7C0;
`endif
            sz    = ($urandom_range(0, 3) == 0);
            wdata = sz ? 32'h0 : $urandom;
            irq   = $urandom_range(0, 1) == 1 && !(m_mstatus[3] && m_mie[11]);
            applyStimulus(op, addr, wdata, sz, 1'b0, 0);
            @(posedge clk);
            #1;
            irq = 1'b0;
         end
      end
      drain();

      $display("[TB] reset during execute");
      wait_ready("rst_mid");
      req_valid    = 1'b1;
      req_op       = 3'b001;
      req_addr     = 12'h340;
      req_wdata    = 32'h5555AAAA;
      req_src_zero = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst       = 1'b1;
      seen_resp = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) seen_resp = 1'b1;
      end
      checkOutput("no_resp_after_rst", 32'(seen_resp), 32'd0);
      rst = 1'b0;
      model_reset();
      expectRead(12'h340, 32'h0);
      drain();

`ifdef CSR_CYCLE_COUNTER_EN
      $display("[TB] cycle counter");
      applyStimulus(3'b010, 12'hB00, 32'h0, 1'b1, 1'b1, 0);
      applyStimulus(3'b010, 12'hB00, 32'h0, 1'b1, 1'b1, 1);
      applyStimulus(3'b001, 12'hB00, 32'h1000, 1'b0, 1'b1, 2);
      applyStimulus(3'b010, 12'hB00, 32'h0, 1'b1, 1'b1, 3);
      applyStimulus(3'b001, 12'hB80, 32'h5, 1'b0, 1'b1, 4);
      applyStimulus(3'b010, 12'hB80, 32'h0, 1'b1, 1'b1, 5);
      drain();
      checkOutput("mcycle_delta", cap_val[1] - cap_val[0], 32'd3);
      checkOutput("mcycle_delta_cycles", cap_val[1] - cap_val[0], 32'(cap_cycle[1] - cap_cycle[0]));
      checkOutput("mcycle_after_write", cap_val[3], 32'h1000 + 32'(cap_cycle[3] - cap_cycle[2]) - 32'd1);
      checkOutput("mcycleh_after_write", cap_val[5], 32'h5);
`else
      $display("[TB] counter addresses unmapped");
      applyStimulus(3'b001, 12'hB00, 32'h1, 1'b0, 1'b0, 0);
      applyStimulus(3'b010, 12'hB80, 32'h0, 1'b1, 1'b0, 0);
      drain();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
